pkt_stim_gen: RTL and testbench

- Synthesisable, parametrised packet source for the NetFPGA-style 64-bit datapath.
- Emits programmable packets on the out_data/out_ctrl/out_wr/out_rdy interface into np_core's input port, for on-chip self-test and regression benches.
- Each packet is one module-header word (ctrl all-ones) followed by payload words; the last payload word carries byte-valid ctrl.
- Supports packet count, inter-packet gap, payload modes, and downstream backpressure.

---
 rtl/pkt_stim_pkg.sv | 37 +++
 rtl/pkt_stim_payload.sv | 31 +++
 rtl/pkt_stim_gen.sv | 171 +++++++++++++++++
 tb/tb_pkt_stim_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_stim_pkg.sv
// Shared definitions for the packet stimulus generator: header layout,
// FSM encoding and packet-geometry helpers.
package pkt_stim_pkg;

  // Bit offsets of the 16-bit fields inside the low 64 bits of the header word
  localparam int HDR_DST_LSB  = 48;
  localparam int HDR_WLEN_LSB = 32;
  localparam int HDR_SRC_LSB  = 16;
  localparam int HDR_LEN_LSB  = 0;

  // pkt_bytes == 0 selects this payload length
  localparam int DEFAULT_LEN = 64;

  // Header ctrl marks every lane; callers slice to their CTRL_WIDTH
  localparam logic [31:0] CTRL_HDR = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_GAP,
    ST_FIN
  } state_t;

  // Number of datapath words needed to carry len bytes
  function automatic int unsigned words_for_len(input int unsigned len,
                                                input int unsigned bpw);
    return (len + bpw - 1) / bpw;
  endfunction

  // Byte-valid ctrl of the last word: one-hot on the last valid lane
  function automatic int unsigned last_ctrl(input int unsigned n,
                                            input int unsigned ctrl_w);
    return 32'd1 << (ctrl_w - n);
  endfunction

endpackage

// File: rtl/pkt_stim_payload.sv
// Combinational lane generator: builds one payload word (MSB lane = lowest
// byte index) plus the byte-valid mask for that word.
module pkt_stim_payload #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    mode,
  input  logic [7:0]              seed,
  input  logic [LEN_WIDTH-1:0]    word_idx,
  input  logic                    last,
  input  logic [LEN_WIDTH-1:0]    last_n,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] byte_vld
);

  localparam int BPW = DATA_WIDTH / 8;

  logic [7:0]                lane_base;
  logic [BPW-1:0][7:0]       lanes;

  // Only the low byte of the running byte index matters: the pattern wraps mod 256
  assign lane_base = 8'(32'(word_idx) * BPW);

  for (genvar j = 0; j < BPW; j++) begin : g_lane
    assign lanes[BPW-1-j]    = mode ? seed : seed + lane_base + 8'(j);
    assign byte_vld[BPW-1-j] = !last || (last_n > LEN_WIDTH'(j));
  end

  assign data = lanes;

endmodule

// File: rtl/pkt_stim_gen.sv
// Programmable packet source for the 64/128/256-bit NetFPGA-style stream:
// header word (ctrl all-ones) then payload, with gap and backpressure support.
module pkt_stim_gen
  import pkt_stim_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  input  logic [LEN_WIDTH-1:0]  pkt_bytes,
  input  logic [CNT_WIDTH-1:0]  gap_cycles,
  input  logic                  mode,
  input  logic [7:0]            seed,
  input  logic [15:0]           src_port,
  input  logic [15:0]           dst_port,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkts_sent
);

  localparam int BPW = DATA_WIDTH / 8;

  state_t               state;
  logic [CNT_WIDTH-1:0] num_q, gap_q, gap_cnt;
  logic [LEN_WIDTH-1:0] len_q, wlen_q, last_n_q, widx;
  logic                 mode_q;
  logic [7:0]           seed_q;
  logic [15:0]          src_q, dst_q;

  logic [LEN_WIDTH-1:0]  len_eff, wlen_c, last_n_c;
  logic [63:0]           hdr;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] pay_raw, pay_word;
  logic [CTRL_WIDTH-1:0] pay_vld;

  // Geometry of the incoming config, evaluated only when start is accepted
  always_comb begin
    len_eff  = (pkt_bytes == '0) ? LEN_WIDTH'(DEFAULT_LEN) : pkt_bytes;
    wlen_c   = LEN_WIDTH'(words_for_len(32'(len_eff), BPW));
    last_n_c = len_eff - LEN_WIDTH'((32'(wlen_c) - 32'd1) * 32'(BPW));
  end

  // Header fields in the low 64 bits; upper lanes of wider datapaths stay 0
  always_comb begin
    hdr = '0;
    hdr[HDR_DST_LSB  +: 16] = dst_q;
    hdr[HDR_WLEN_LSB +: 16] = 16'(wlen_q);
    hdr[HDR_SRC_LSB  +: 16] = src_q;
    hdr[HDR_LEN_LSB  +: 16] = 16'(len_q);
  end

  assign is_last = (widx == wlen_q - LEN_WIDTH'(1));

  pkt_stim_payload #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_payload (
    .mode     (mode_q),
    .seed     (seed_q),
    .word_idx (widx),
    .last     (is_last),
    .last_n   (last_n_q),
    .data     (pay_raw),
    .byte_vld (pay_vld)
  );

  // Invalid lanes of the last word are driven to zero
  for (genvar i = 0; i < CTRL_WIDTH; i++) begin : g_mask
    assign pay_word[i*8 +: 8] = pay_vld[i] ? pay_raw[i*8 +: 8] : 8'h00;
  end

  // Run FSM: one word per accepted out_rdy edge, all stream outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      len_q     <= '0;
      wlen_q    <= '0;
      last_n_q  <= '0;
      widx      <= '0;
      mode_q    <= 1'b0;
      seed_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      out_wr <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q     <= num_pkts;
            gap_q     <= gap_cycles;
            len_q     <= len_eff;
            wlen_q    <= wlen_c;
            last_n_q  <= last_n_c;
            mode_q    <= mode;
            seed_q    <= seed;
            src_q     <= src_port;
            dst_q     <= dst_port;
            pkts_sent <= '0;
            if (num_pkts != '0) begin
              state <= ST_HDR;
              busy  <= 1'b1;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (out_rdy) begin
            out_data <= DATA_WIDTH'(hdr);
            out_ctrl <= CTRL_HDR[CTRL_WIDTH-1:0];
            out_wr   <= 1'b1;
            widx     <= '0;
            state    <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (out_rdy) begin
            out_data <= pay_word;
            out_wr   <= 1'b1;
            if (is_last) begin
              out_ctrl  <= CTRL_WIDTH'(last_ctrl(32'(last_n_q), CTRL_WIDTH));
              pkts_sent <= pkts_sent + CNT_WIDTH'(1);
              if (pkts_sent + CNT_WIDTH'(1) == num_q) begin
                state <= ST_FIN;
              end else if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= ST_GAP;
              end else begin
                state <= ST_HDR;
              end
            end else begin
              out_ctrl <= '0;
              widx     <= widx + LEN_WIDTH'(1);
            end
          end
        end
        ST_GAP: begin
          // Gap runs on the clock alone, independent of out_rdy
          if (gap_cnt == CNT_WIDTH'(1)) state <= ST_HDR;
          else gap_cnt <= gap_cnt - CNT_WIDTH'(1);
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_stim_gen.sv
// Self-checking bench for pkt_stim_gen (64-bit datapath): directed scenarios
// plus randomized runs with random backpressure against a packet-level model.
module tb_pkt_stim_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_pkts = '0, pkt_bytes = '0, gap_cycles = '0;
  logic        mode = 1'b0;
  logic [7:0]  seed = '0;
  logic [15:0] src_port = '0, dst_port = '0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr, busy, done;
  logic        out_rdy = 1'b1;
  logic [15:0] pkts_sent;

  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, done_base = 0, t_start = 0;
  bit bp = 1'b0;

  logic [63:0] got_d[$], exp_d[$];
  logic [7:0]  got_c[$], exp_c[$];
  int          got_t[$];

  pkt_stim_gen dut (
    .clk(clk), .reset(reset), .start(start), .num_pkts(num_pkts),
    .pkt_bytes(pkt_bytes), .gap_cycles(gap_cycles), .mode(mode), .seed(seed),
    .src_port(src_port), .dst_port(dst_port), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy), .busy(busy),
    .done(done), .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every written word with its cycle stamp, and count done pulses
  always @(negedge clk) begin
    if (!reset && out_wr) begin
      got_d.push_back(out_data);
      got_c.push_back(out_ctrl);
      got_t.push_back(cyc);
    end
    if (!reset && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected word stream for a whole run, built byte by byte from the packet rules
  task automatic model(input int n, input int pb, input bit md, input logic [7:0] sd,
                       input logic [15:0] sp, input logic [15:0] dp);
    int L, wl, k;
    logic [63:0] d;
    logic [7:0]  c;
    L  = (pb == 0) ? 64 : pb;
    wl = (L + 7) / 8;
    exp_d.delete(); exp_c.delete();
    for (int p = 0; p < n; p++) begin
      exp_d.push_back({dp, 16'(wl), sp, 16'(L)});
      exp_c.push_back(8'hff);
      for (int w = 0; w < wl; w++) begin
        d = '0; c = 8'h00;
        for (int b = 0; b < 8; b++) begin
          k = w*8 + b;
          if (k < L) d[63-8*b -: 8] = md ? sd : 8'(sd + k);
        end
        if (w == wl-1) c = 8'h80 >> (L - 1 - w*8);
        exp_d.push_back(d);
        exp_c.push_back(c);
      end
    end
  endtask

  task automatic do_start(input int n, input int pb, input int gp, input bit md,
                          input logic [7:0] sd, input logic [15:0] sp, input logic [15:0] dp);
    @(posedge clk); #1;
    got_d.delete(); got_c.delete(); got_t.delete();
    done_base  = done_cnt;
    num_pkts   = 16'(n);
    pkt_bytes  = 16'(pb);
    gap_cycles = 16'(gp);
    mode = md; seed = sd; src_port = sp; dst_port = dp;
    start   = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    model(n, pb, md, sd, sp, dp);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      @(posedge clk); #1;
      out_rdy = bp ? ($urandom_range(3) != 0) : 1'b1;
      k++;
    end
    out_rdy = 1'b1;
    chk("done_seen", done_cnt != done_base, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - done_base, 1);
    chk("busy_clear", busy, 0);
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (got_d.size() < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_words", got_d.size() >= n, 1);
  endtask

  task automatic cmp_run(input string tag);
    chk({tag, "_len"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_c%0d", tag, i), got_c[i], exp_c[i]);
    end
  endtask

  initial begin
    int rn;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", out_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", pkts_sent, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ctrl", out_ctrl, 0);
    reset = 1'b0;

    // 106-byte single packet
    do_start(1, 106, 0, 0, 8'h00, 16'h0004, 16'h0000);
    chk("s1_busy", busy, 1);
    wait_done(200);
    cmp_run("s1");
    chk("s1_hdr", got_d[0], 64'h0000000e0004006a);
    chk("s1_pay0", got_d[1], 64'h0001020304050607);
    chk("s1_lastc", got_c[14], 8'h40);
    chk("s1_lastd", got_d[14], 64'h6869000000000000);
    chk("s1_latency", got_t[0] - t_start, 2);
    chk("s1_sent", pkts_sent, 1);

    // Three back-to-back 64-byte packets
    do_start(3, 64, 0, 0, 8'h30, 16'h0001, 16'h0002);
    wait_done(200);
    cmp_run("s2");
    chk("s2_nobubble", got_t[26] - got_t[0], 26);
    chk("s2_sent", pkts_sent, 3);

    // Gap of 5 between two packets
    do_start(2, 64, 5, 0, 8'h00, 16'h0001, 16'h0002);
    wait_done(200);
    cmp_run("s3");
    chk("s3_gap", got_t[9] - got_t[8], 6);
    chk("s3_sent", pkts_sent, 2);

    // Backpressure on the header and mid-payload
    out_rdy = 1'b0;
    do_start(1, 106, 0, 0, 8'h00, 16'h0004, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("s4_hold_hdr", got_d.size(), 0);
    out_rdy = 1'b1;
    wait_words(5);
    @(posedge clk); #1;
    out_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    out_rdy = 1'b1;
    wait_done(200);
    cmp_run("s4");

    // Reset in the middle of the second packet's payload
    do_start(2, 106, 0, 0, 8'h00, 16'h0004, 16'h0000);
    wait_words(22);
    @(posedge clk); #1;
    chk("s5_sent_pre", pkts_sent, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("s5_wr", out_wr, 0);
    chk("s5_busy", busy, 0);
    chk("s5_sent", pkts_sent, 0);
    reset = 1'b0;
    do_start(1, 106, 0, 0, 8'h00, 16'h0004, 16'h0000);
    wait_done(200);
    cmp_run("s5_after");

    // num_pkts = 0
    do_start(0, 16, 0, 0, 8'h00, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("e0_done", done_cnt - done_base, 1);
    chk("e0_nowr", got_d.size(), 0);
    chk("e0_busy", busy, 0);

    // pkt_bytes = 0 means 64 bytes
    do_start(1, 0, 0, 0, 8'h10, 16'h0007, 16'h0009);
    wait_done(200);
    cmp_run("e1");
    chk("e1_wlen", got_d[0][47:32], 8);
    chk("e1_len", got_d[0][15:0], 64);

    // Single byte, fill mode
    do_start(1, 1, 0, 1, 8'haa, 16'h0001, 16'h0001);
    wait_done(200);
    cmp_run("e2");
    chk("e2_lastc", got_c[1], 8'h80);
    chk("e2_lastd", got_d[1], 64'haa00000000000000);

    // start while busy is ignored
    do_start(2, 16, 2, 0, 8'h55, 16'h0003, 16'h0004);
    repeat (3) @(posedge clk);
    #1;
    num_pkts = 16'd5; pkt_bytes = 16'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    cmp_run("e3");
    chk("e3_sent", pkts_sent, 2);

    // Randomized runs with random backpressure
    bp = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rn = $urandom_range(3, 1);
      do_start(rn, $urandom_range(40, 0), $urandom_range(3, 0), 1'($urandom_range(1)),
               8'($urandom), 16'($urandom), 16'($urandom));
      wait_done(3000);
      cmp_run($sformatf("r%0d", r));
      chk($sformatf("r%0d_sent", r), pkts_sent, rn);
    end
    bp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
